// File: rtl/execute_stage_mc.sv
// LEGv8 execute stage with handshaked EX/MEM slot and an iterative
// radix-2 shift-add multiplier.
module execute_stage_mc #(
   parameter int N        = 64,
   parameter int BR_SHIFT = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         valid_E,
   output logic         ready_E,
   input  logic [1:0]   AluSrc,
   input  logic [3:0]   AluControl,
   input  logic         MulOp,
   input  logic [N-1:0] PC_E,
   input  logic [N-1:0] signImm_E,
   input  logic [N-1:0] readData1_E,
   input  logic [N-1:0] readData2_E,
   input  logic [N-1:0] readData3_E,
   input  logic         ready_M,
   output logic         valid_M,
   output logic [N-1:0] PCBranch_M,
   output logic [N-1:0] aluResult_M,
   output logic [N-1:0] writeData_M,
   output logic         zero_M,
   output logic         busy
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [0:0] {
      IDLE,
      MUL
   } state_t;

   state_t         state_q, state_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [N-1:0]   acc_q, acc_d;
   logic [N-1:0]   a_q, a_d;
   logic [N-1:0]   b_q, b_d;
   logic [N-1:0]   pcb_q, pcb_d;
   logic [N-1:0]   wd_q, wd_d;

   logic           valid_q, valid_d;
   logic [N-1:0]   pcbm_q, pcbm_d;
   logic [N-1:0]   alu_q, alu_d;
   logic [N-1:0]   wdm_q, wdm_d;
   logic           zero_q, zero_d;
   logic           busy_q, busy_d;

   logic [N-1:0]   b_mux;
   logic [N-1:0]   alu_res;
   logic [N-1:0]   pcb_in;
   logic [N-1:0]   step_add;
   logic [N-1:0]   acc_nxt;
   logic           accept;
   logic           last;

   assign ready_E = (state_q == IDLE) && (!valid_q || ready_M);
   assign accept  = valid_E && ready_E;
   assign last    = (cnt_q == CW'(N - 1));

   always_comb begin
      b_mux = readData3_E;
      case (AluSrc)
         2'b00:   b_mux = readData2_E;
         2'b01:   b_mux = signImm_E;
         default: b_mux = readData3_E;
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (AluControl)
         4'b0000: alu_res = readData1_E & b_mux;
         4'b0001: alu_res = readData1_E | b_mux;
         4'b0010: alu_res = readData1_E + b_mux;
         4'b0110: alu_res = readData1_E - b_mux;
         4'b0111: alu_res = b_mux;
         4'b1100: alu_res = ~(readData1_E | b_mux);
         default: alu_res = '0;
      endcase
   end

   assign pcb_in   = PC_E + (signImm_E << BR_SHIFT);
   assign step_add = b_q[cnt_q] ? (a_q << cnt_q) : '0;
   assign acc_nxt  = acc_q + step_add;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      a_d     = a_q;
      b_d     = b_q;
      pcb_d   = pcb_q;
      wd_d    = wd_q;
      // a consumed slot empties unless something reloads it below
      valid_d = valid_q && !ready_M;
      pcbm_d  = pcbm_q;
      alu_d   = alu_q;
      wdm_d   = wdm_q;
      zero_d  = zero_q;
      busy_d  = busy_q;
      case (state_q)
         IDLE: begin
            if (accept && MulOp) begin
               a_d     = readData1_E;
               b_d     = b_mux;
               pcb_d   = pcb_in;
               wd_d    = readData2_E;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = MUL;
               busy_d  = 1'b1;
            end else if (accept) begin
               valid_d = 1'b1;
               pcbm_d  = pcb_in;
               alu_d   = alu_res;
               wdm_d   = readData2_E;
               zero_d  = (alu_res == '0);
            end
         end
         MUL: begin
            acc_d = acc_nxt;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
               cnt_d   = '0;
               state_d = IDLE;
               busy_d  = 1'b0;
               valid_d = 1'b1;
               pcbm_d  = pcb_q;
               alu_d   = acc_nxt;
               wdm_d   = wd_q;
               zero_d  = (acc_nxt == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         pcb_q   <= '0;
         wd_q    <= '0;
         valid_q <= 1'b0;
         pcbm_q  <= '0;
         alu_q   <= '0;
         wdm_q   <= '0;
         zero_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         a_q     <= a_d;
         b_q     <= b_d;
         pcb_q   <= pcb_d;
         wd_q    <= wd_d;
         valid_q <= valid_d;
         pcbm_q  <= pcbm_d;
         alu_q   <= alu_d;
         wdm_q   <= wdm_d;
         zero_q  <= zero_d;
         busy_q  <= busy_d;
      end
   end

   assign valid_M     = valid_q;
   assign PCBranch_M  = pcbm_q;
   assign aluResult_M = alu_q;
   assign writeData_M = wdm_q;
   assign zero_M      = zero_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_execute_stage_mc.sv
// Directed bench for execute_stage_mc at N=64 and N=16.
module tb_execute_stage_mc;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        valid_E, ready_E, MulOp, ready_M, valid_M, zero_M, busy;
   logic [1:0]  AluSrc;
   logic [3:0]  AluControl;
   logic [63:0] PC_E, signImm_E, rd1, rd2, rd3;
   logic [63:0] PCBranch_M, aluResult_M, writeData_M;

   logic        s_valid_E, s_ready_E, s_MulOp, s_ready_M, s_valid_M, s_zero_M, s_busy;
   logic [1:0]  s_AluSrc;
   logic [3:0]  s_AluControl;
   logic [15:0] s_PC_E, s_signImm_E, s_rd1, s_rd2, s_rd3;
   logic [15:0] s_PCBranch_M, s_aluResult_M, s_writeData_M;

   execute_stage_mc #(.N(64), .BR_SHIFT(2)) dut (
      .clk(clk), .reset(reset), .valid_E(valid_E), .ready_E(ready_E),
      .AluSrc(AluSrc), .AluControl(AluControl), .MulOp(MulOp),
      .PC_E(PC_E), .signImm_E(signImm_E), .readData1_E(rd1),
      .readData2_E(rd2), .readData3_E(rd3), .ready_M(ready_M),
      .valid_M(valid_M), .PCBranch_M(PCBranch_M), .aluResult_M(aluResult_M),
      .writeData_M(writeData_M), .zero_M(zero_M), .busy(busy)
   );

   execute_stage_mc #(.N(16), .BR_SHIFT(2)) dut16 (
      .clk(clk), .reset(reset), .valid_E(s_valid_E), .ready_E(s_ready_E),
      .AluSrc(s_AluSrc), .AluControl(s_AluControl), .MulOp(s_MulOp),
      .PC_E(s_PC_E), .signImm_E(s_signImm_E), .readData1_E(s_rd1),
      .readData2_E(s_rd2), .readData3_E(s_rd3), .ready_M(s_ready_M),
      .valid_M(s_valid_M), .PCBranch_M(s_PCBranch_M),
      .aluResult_M(s_aluResult_M), .writeData_M(s_writeData_M),
      .zero_M(s_zero_M), .busy(s_busy)
   );

   int n_run  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [3:0]  ctl;
      logic [63:0] a;
      logic [63:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[6];
   int lat, bcnt, vcnt;

   initial begin
      vecs[0] = '{4'b0000, 64'hF0F0, 64'hFF00, 64'hF000};
      vecs[1] = '{4'b0001, 64'hF0F0, 64'h0F00, 64'hFFF0};
      vecs[2] = '{4'b0110, 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[3] = '{4'b1100, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[4] = '{4'b0011, 64'd7, 64'd9, 64'd0};
      vecs[5] = '{4'b0010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0};

      reset = 1'b1;
      valid_E = 0; MulOp = 0; ready_M = 1; AluSrc = 0; AluControl = 0;
      PC_E = 0; signImm_E = 0; rd1 = 0; rd2 = 0; rd3 = 0;
      s_valid_E = 0; s_MulOp = 0; s_ready_M = 1; s_AluSrc = 0;
      s_AluControl = 0; s_PC_E = 0; s_signImm_E = 0;
      s_rd1 = 0; s_rd2 = 0; s_rd3 = 0;
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_valid", {63'd0, valid_M}, 64'd0);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_ready", {63'd0, ready_E}, 64'd1);
      check("rst_alu", aluResult_M, 64'd0);

      // ADD with immediate operand
      valid_E = 1; AluControl = 4'b0010; AluSrc = 2'd1;
      rd1 = 5; signImm_E = 3; PC_E = 64'h100; rd2 = 64'h55;
      tick();
      check("add_alu", aluResult_M, 64'd8);
      check("add_pcb", PCBranch_M, 64'h10C);
      check("add_zero", {63'd0, zero_M}, 64'd0);
      check("add_valid", {63'd0, valid_M}, 64'd1);
      check("add_wd", writeData_M, 64'h55);

      AluControl = 4'b0110; AluSrc = 2'd0; rd1 = 7; rd2 = 7;
      tick();
      check("sub_alu", aluResult_M, 64'd0);
      check("sub_zero", {63'd0, zero_M}, 64'd1);

      AluControl = 4'b0111; AluSrc = 2'd2; rd3 = 9;
      tick();
      check("passb_alu", aluResult_M, 64'd9);

      AluSrc = 2'd0;
      for (int i = 0; i < 6; i++) begin
         AluControl = vecs[i].ctl; rd1 = vecs[i].a; rd2 = vecs[i].b;
         tick();
         check($sformatf("vec%0d_alu", i), aluResult_M, vecs[i].exp);
         check($sformatf("vec%0d_zero", i), {63'd0, zero_M},
               {63'd0, vecs[i].exp == 64'd0});
      end

      // 64-cycle multiply; inputs scrambled after the transfer
      MulOp = 1; AluSrc = 2'd0; rd1 = 64'hFFFF_FFFF_FFFF_FFFF; rd2 = 3;
      PC_E = 64'h200; signImm_E = 1;
      tick();
      valid_E = 0; MulOp = 0; rd1 = 64'h1234; rd2 = 64'h77;
      PC_E = 0; signImm_E = 0;
      lat = 0; bcnt = 0;
      while (!valid_M && lat < 200) begin
         if (busy && !ready_E) bcnt++;
         tick();
         lat++;
      end
      check("mul_latency", 64'(lat), 64'd64);
      check("mul_busy_cycles", 64'(bcnt), 64'd64);
      check("mul_alu", aluResult_M, 64'hFFFF_FFFF_FFFF_FFFD);
      check("mul_pcb", PCBranch_M, 64'h204);
      check("mul_wd", writeData_M, 64'd3);
      check("mul_busy_done", {63'd0, busy}, 64'd0);
      tick();
      check("mul_drain", {63'd0, valid_M}, 64'd0);

      // back-pressure with a queued ADD
      ready_M = 0; valid_E = 1; MulOp = 0; AluControl = 4'b0010;
      AluSrc = 2'd1; rd1 = 1; signImm_E = 1;
      tick();
      check("bp_first", aluResult_M, 64'd2);
      rd1 = 10; signImm_E = 20;
      #1;
      check("bp_ready_lo", {63'd0, ready_E}, 64'd0);
      tick(); tick(); tick();
      check("bp_hold_alu", aluResult_M, 64'd2);
      check("bp_hold_valid", {63'd0, valid_M}, 64'd1);
      check("bp_hold_ready", {63'd0, ready_E}, 64'd0);
      ready_M = 1;
      #1;
      check("bp_ready_hi", {63'd0, ready_E}, 64'd1);
      tick();
      check("bp_next_alu", aluResult_M, 64'd30);
      check("bp_next_valid", {63'd0, valid_M}, 64'd1);
      valid_E = 0;
      tick();
      check("bp_no_dup", {63'd0, valid_M}, 64'd0);

      // reset in the middle of a multiply
      valid_E = 1; MulOp = 1; AluSrc = 2'd0; rd1 = 64'h99; rd2 = 64'hFF;
      tick();
      valid_E = 0; MulOp = 0;
      repeat (30) tick();
      check("mr_busy_pre", {63'd0, busy}, 64'd1);
      reset = 1;
      tick();
      check("mr_valid", {63'd0, valid_M}, 64'd0);
      check("mr_busy", {63'd0, busy}, 64'd0);
      check("mr_alu", aluResult_M, 64'd0);
      check("mr_pcb", PCBranch_M, 64'd0);
      check("mr_wd", writeData_M, 64'd0);
      check("mr_zero", {63'd0, zero_M}, 64'd0);
      check("mr_ready", {63'd0, ready_E}, 64'd1);
      reset = 0;
      tick();

      // stream of 8 ADDs, no bubbles
      ready_M = 1; valid_E = 1; AluControl = 4'b0010; AluSrc = 2'd1;
      signImm_E = 100; vcnt = 0;
      for (int i = 0; i < 8; i++) begin
         rd1 = 64'(i);
         tick();
         if (valid_M) vcnt++;
         check($sformatf("strm%0d_alu", i), aluResult_M, 64'(i + 100));
      end
      valid_E = 0;
      check("strm_count", 64'(vcnt), 64'd8);
      tick();
      check("strm_end", {63'd0, valid_M}, 64'd0);

      // N=16: 16-cycle multiply and truncated branch target
      s_valid_E = 1; s_MulOp = 1; s_AluSrc = 2'd0;
      s_rd1 = 16'hFFFF; s_rd2 = 3; s_PC_E = 16'h10; s_signImm_E = 16'h4000;
      tick();
      s_valid_E = 0; s_rd1 = 0; s_rd2 = 0;
      lat = 0;
      while (!s_valid_M && lat < 100) begin
         tick();
         lat++;
      end
      check("n16_latency", 64'(lat), 64'd16);
      check("n16_alu", {48'd0, s_aluResult_M}, 64'hFFFD);
      check("n16_pcb", {48'd0, s_PCBranch_M}, 64'h10);
      tick();
      s_valid_E = 1; s_MulOp = 1; s_rd1 = 16'd300; s_rd2 = 16'd300;
      tick();
      s_valid_E = 0;
      lat = 0;
      while (!s_valid_M && lat < 100) begin
         tick();
         lat++;
      end
      check("n16_lat2", 64'(lat), 64'd16);
      check("n16_alu2", {48'd0, s_aluResult_M}, 64'd24464);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
